// File: rtl/a51_sequencer.sv
// ---------------------------------------------------------------------------
// a51_sequencer
//
// Control FSM for one complete A5/1 keystream session over three external
// clock-enabled LFSRs (19/22/23 bits). A session runs
//   CLEAR -> KEY (serial, LSB first) -> FRAME (serial, LSB first)
//         -> MIX (majority clocked, output discarded)
//         -> OUT (majority clocked, keystream valid) -> IDLE + done pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, forces IDLE
//   start      session request, accepted only in IDLE
//   abort      synchronous session abort (no done pulse)
//   key        session key, sampled on accepted start
//   frame      frame number, sampled on accepted start
//   clk_bits   clocking taps {r23[10], r22[10], r19[8]}
//   lfsr_clr   synchronous clear request to all LFSRs
//   load_mode  1: LFSR input = feedback ^ load_bit, 0: plain feedback
//   load_bit   serial key/frame bit
//   en19/22/23 per-LFSR shift enables
//   ks_valid   keystream bit is valid at this edge
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last keystream bit
//   state      current state encoding (debug)
// ---------------------------------------------------------------------------
module a51_sequencer #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int OUT_BITS   = 228
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic [2:0]            clk_bits,
    output logic                  lfsr_clr,
    output logic                  load_mode,
    output logic                  load_bit,
    output logic                  en19,
    output logic                  en22,
    output logic                  en23,
    output logic                  ks_valid,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    localparam int SH_W    = KEY_BITS + FRAME_BITS;
    localparam int MAX_A   = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int MAX_B   = (MIX_CYCLES > OUT_BITS) ? MIX_CYCLES : OUT_BITS;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // At least 9 bits so the default lengths always fit with headroom.
    localparam int CNT_W   = ($clog2(MAX_LEN) > 9) ? $clog2(MAX_LEN) : 9;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(OUT_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_KEY   = 3'd2,
        S_FRAME = 3'd3,
        S_MIX   = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [SH_W-1:0]  shreg;
    logic             done_r;

    // Majority of the three clocking taps.
    function automatic logic maj3(input logic [2:0] b);
        return (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
    endfunction

    // Sequencing state: state, cycle counter, load shift register, done flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= S_IDLE;
            cnt    <= '0;
            shreg  <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            // abort wins over every normal transition, but only when busy
            if (abort && (st != S_IDLE)) begin
                st    <= S_IDLE;
                cnt   <= '0;
                shreg <= '0;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (start) begin
                            st    <= S_CLEAR;
                            shreg <= {frame, key};   // key LSB lands in shreg[0]
                            cnt   <= '0;
                        end
                    end
                    S_CLEAR: st <= S_KEY;
                    S_KEY: begin
                        shreg <= shreg >> 1;
                        if (cnt == KEY_LAST) begin
                            st  <= S_FRAME;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_FRAME: begin
                        shreg <= shreg >> 1;
                        if (cnt == FRAME_LAST) begin
                            st  <= S_MIX;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_MIX: begin
                        if (cnt == MIX_LAST) begin
                            st  <= S_OUT;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_OUT: begin
                        if (cnt == OUT_LAST) begin
                            st     <= S_IDLE;
                            cnt    <= '0;
                            done_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        // unused encodings recover to IDLE
                        st    <= S_IDLE;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                endcase
            end
        end
    end

    // Output decode: combinational from registered state/shreg and live taps.
    always_comb begin
        logic m;
        m         = maj3(clk_bits);
        lfsr_clr  = 1'b0;
        load_mode = 1'b0;
        load_bit  = 1'b0;
        en19      = 1'b0;
        en22      = 1'b0;
        en23      = 1'b0;
        ks_valid  = 1'b0;
        case (st)
            S_CLEAR: lfsr_clr = 1'b1;
            S_KEY, S_FRAME: begin
                en19      = 1'b1;
                en22      = 1'b1;
                en23      = 1'b1;
                load_mode = 1'b1;
                load_bit  = shreg[0];
            end
            S_MIX, S_OUT: begin
                // a register steps only when its tap agrees with the majority
                en19     = (clk_bits[0] == m);
                en22     = (clk_bits[1] == m);
                en23     = (clk_bits[2] == m);
                ks_valid = (st == S_OUT);
            end
            default: ;
        endcase
    end

    assign busy  = (st != S_IDLE);
    assign done  = done_r;
    assign state = st;

endmodule

// File: doc/a51_sequencer.md
Name: a51_sequencer

Overview:
Control FSM that drives one complete A5/1 keystream session over the three clock-enabled LFSRs (19/22/23 bits) and their feedback muxes.
- On `start` it latches a session key and frame number, then runs the session in order: LFSR clear, serial key load, serial frame load, majority-clocked mixing, and keystream output.
- It generates the per-LFSR shift enables, the load-mode select, the serial load bit, and the keystream-valid strobe.
- It replaces the free-running stage counter with a start/busy/done handshake.

Parameters:
KEY_BITS, 64, session key length in bits (serial load cycles)
FRAME_BITS, 22, frame number length in bits
MIX_CYCLES, 100, majority-clocked cycles with output discarded
OUT_BITS, 228, number of valid keystream bits per session

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start  in  1  session request; accepted only when state=IDLE
abort  in  1  synchronous; ends any active session, no done pulse
key  in  KEY_BITS  session key, sampled on accepted start
frame  in  FRAME_BITS  frame number, sampled on accepted start
clk_bits  in  3  clocking taps: [0]=r19[8], [1]=r22[10], [2]=r23[10]
lfsr_clr  out  1  synchronous clear request to all three LFSRs
load_mode  out  1  1 selects feedback^load_bit as LFSR input; 0 selects plain feedback
load_bit  out  1  serial key/frame bit
en19, en22, en23  out  1 each  LFSR shift enables
ks_valid  out  1  keystream bit (r19[18]^r22[21]^r23[22]) is valid at this edge
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last keystream bit
state  out  3  current state encoding, for debug

Behaviour:
- States: IDLE=0, CLEAR=1, KEY=2, FRAME=3, MIX=4, OUT=5; 6 and 7 are unused and return to IDLE.
- Registers:
  - state
  - 9-bit cycle counter cnt; sized to hold OUT_BITS-1 and MIX_CYCLES-1
  - load shift register shreg of KEY_BITS+FRAME_BITS bits
  - done flop
- Reset (asynchronous, active-high): state=IDLE, cnt=0, shreg=0, done=0. As a result every output is 0.
- IDLE:
  - Outputs: all enables 0, load_mode 0, load_bit 0.
  - start=1 → CLEAR; shreg={frame,key}, so the key LSB is shreg[0]; cnt=0.
- CLEAR: exactly 1 cycle.
  - Outputs: lfsr_clr=1, enables 0.
  - → KEY.
- KEY: KEY_BITS cycles.
  - Outputs: en19=en22=en23=1, load_mode=1, load_bit=shreg[0].
  - Each cycle: shreg shifts right by 1 with zero fill; cnt increments.
  - At cnt==KEY_BITS-1: → FRAME, cnt=0.
  - Key is loaded LSB first.
- FRAME: FRAME_BITS cycles, same outputs as KEY.
  - Frame is loaded LSB first.
  - At cnt==FRAME_BITS-1: → MIX, cnt=0.
- MIX: MIX_CYCLES cycles.
  - Outputs: load_mode=0, load_bit=0, majority enables.
  - At cnt==MIX_CYCLES-1: → OUT, cnt=0.
- OUT: OUT_BITS cycles.
  - Outputs: majority enables, ks_valid=1.
  - The consumer samples the keystream at each edge where ks_valid=1, i.e. the value before that cycle's shift.
  - At cnt==OUT_BITS-1: → IDLE and done<=1 for the following cycle.
- Majority enables, MIX and OUT only: m=maj(clk_bits); enN = (tap_N == m). At least two enables are always 1.
- Output timing: en*, load_mode, load_bit, lfsr_clr and ks_valid are combinational decodes of registered state/shreg plus clk_bits. done is registered.
- Session timing: start is accepted at edge E0.
  - CLEAR is cycle 1.
  - KEY is cycles 2–65.
  - FRAME is cycles 66–87.
  - MIX is cycles 88–187.
  - OUT is cycles 188–415.
  - done=1 in cycle 416.
- start while busy: ignored, with no effect on state, cnt or shreg.
- start in the cycle where done=1: accepted, because state is already IDLE.
- abort: → IDLE at the next edge from any busy state. cnt=0, shreg=0, done stays 0. abort has priority over the normal transition; abort in IDLE has no effect.
- Reset mid-session: immediate return to IDLE with all outputs 0. No done pulse.

Test Plan:
1. Assert reset during KEY (cycle 30) → state=0, busy=0, all enables=0 without waiting for a clock edge; after reset release, outputs stay 0 until start.
2. start with key=64'h1223456789ABCDEF, frame=22'h000134, clk_bits=3'b000 → lfsr_clr=1 in cycle 1 only.
   - load_bit in cycles 2–9 = 1,1,1,1,0,1,1,1.
   - load_bit in cycles 66–74 = 0,0,1,0,1,1,0,0,1.
   - en19/en22/en23=1 throughout cycles 2–415.
   - ks_valid high for exactly 228 cycles; done=1 in cycle 416 only.
3. In MIX, drive clk_bits=3'b011 → en19=1, en22=1, en23=0.
   - clk_bits=3'b100 → en19=1, en22=1, en23=0.
   - clk_bits=3'b110 → en19=0, en22=1, en23=1.
   - clk_bits=3'b111 → all enables 1.
4. Pulse start in cycles 50 and 300 of a session → no restart; done still lands in cycle 416. A start in the done cycle begins a new session (lfsr_clr in the next cycle).
5. Assert abort in MIX (cycle 120) → IDLE at the next edge, all enables 0, done never asserts, ks_valid never asserts.
6. Connect to the three LFSRs with the golden key and frame → the 228 sampled keystream bits match the software A5/1 model bit for bit.
